// File: rtl/mux_arbitrado.sv
// Registered channel selector with valid/ready flow control on every side.
// Mode 0 picks the channel named by selecao; mode 1 round-robins among valid channels.
module mux_arbitrado #(
    parameter int unsigned LARGURA      = 8,
    parameter int unsigned NUM_ENTRADAS = 4,
    localparam int unsigned LARG_SEL    = $clog2(NUM_ENTRADAS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_ENTRADAS*LARGURA-1:0] entradas,
    input  logic [NUM_ENTRADAS-1:0]         validos,
    output logic [NUM_ENTRADAS-1:0]         prontos,
    input  logic                            modo,
    input  logic [LARG_SEL-1:0]             selecao,
    output logic [LARGURA-1:0]              saida,
    output logic [LARG_SEL-1:0]             canal_saida,
    output logic                            saida_valida,
    input  logic                            saida_pronta
);

    logic [LARGURA-1:0]  canais [NUM_ENTRADAS];
    logic [LARGURA-1:0]  saida_q, saida_d;
    logic [LARG_SEL-1:0] canal_q, canal_d;
    logic [LARG_SEL-1:0] ponteiro_q, ponteiro_d;
    logic                valida_q, valida_d;
    logic                livre;
    logic                concede;
    logic [LARG_SEL-1:0] indice;
    logic [LARG_SEL-1:0] candidato;
    int unsigned         posicao;

    for (genvar g = 0; g < NUM_ENTRADAS; g++) begin : g_canais
        assign canais[g] = entradas[g*LARGURA +: LARGURA];
    end

    assign livre = !valida_q || saida_pronta;

    always_comb begin
        concede   = 1'b0;
        indice    = '0;
        candidato = '0;
        posicao   = 0;
        if (!modo) begin
            // Indices beyond the last channel simply never grant.
            if (32'(selecao) < NUM_ENTRADAS) begin
                if (validos[selecao]) begin
                    concede = 1'b1;
                    indice  = selecao;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_ENTRADAS; i++) begin
                posicao = 32'(ponteiro_q) + i;
                if (posicao >= NUM_ENTRADAS) begin
                    posicao = posicao - NUM_ENTRADAS;
                end
                candidato = LARG_SEL'(posicao);
                if (!concede && validos[candidato]) begin
                    concede = 1'b1;
                    indice  = candidato;
                end
            end
        end
    end

    always_comb begin
        prontos = '0;
        if (concede) begin
            prontos[indice] = livre;
        end
    end

    always_comb begin
        saida_d    = saida_q;
        canal_d    = canal_q;
        valida_d   = valida_q;
        ponteiro_d = ponteiro_q;
        if (livre) begin
            if (concede) begin
                saida_d  = canais[indice];
                canal_d  = indice;
                valida_d = 1'b1;
                // Explicit wrap so non-power-of-two channel counts skip unused indices.
                if (32'(indice) == NUM_ENTRADAS - 1) begin
                    ponteiro_d = '0;
                end else begin
                    ponteiro_d = indice + LARG_SEL'(1);
                end
            end else begin
                valida_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            saida_q    <= '0;
            canal_q    <= '0;
            valida_q   <= 1'b0;
            ponteiro_q <= '0;
        end else begin
            saida_q    <= saida_d;
            canal_q    <= canal_d;
            valida_q   <= valida_d;
            ponteiro_q <= ponteiro_d;
        end
    end

    assign saida        = saida_q;
    assign canal_saida  = canal_q;
    assign saida_valida = valida_q;

endmodule

// File: tb/tb_mux_arbitrado.sv
// Scoreboard bench for mux_arbitrado: a 4-channel and a 3-channel instance on one clock.
module tb_mux_arbitrado;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    typedef struct packed {
        logic [1:0] canal;
        logic [7:0] dado;
    } item_t;

    item_t sb[$];
    item_t esp;

    logic [31:0] entradas4;
    logic [3:0]  validos4, prontos4;
    logic        modo4, valida4, pronta4;
    logic [1:0]  selecao4, canal4;
    logic [7:0]  saida4;

    logic [23:0] entradas3;
    logic [2:0]  validos3, prontos3;
    logic        modo3, valida3, pronta3;
    logic [1:0]  selecao3, canal3;
    logic [7:0]  saida3;

    mux_arbitrado #(.LARGURA(8), .NUM_ENTRADAS(4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .entradas     (entradas4),
        .validos      (validos4),
        .prontos      (prontos4),
        .modo         (modo4),
        .selecao      (selecao4),
        .saida        (saida4),
        .canal_saida  (canal4),
        .saida_valida (valida4),
        .saida_pronta (pronta4)
    );

    mux_arbitrado #(.LARGURA(8), .NUM_ENTRADAS(3)) dut3 (
        .clock        (clock),
        .reset        (reset),
        .entradas     (entradas3),
        .validos      (validos3),
        .prontos      (prontos3),
        .modo         (modo3),
        .selecao      (selecao3),
        .saida        (saida3),
        .canal_saida  (canal3),
        .saida_valida (valida3),
        .saida_pronta (pronta3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        entradas4 = {8'h13, 8'h12, 8'h11, 8'h10};
        validos4  = 4'b1111;
        modo4     = 1'b0;
        selecao4  = 2'd0;
        pronta4   = 1'b1;
        entradas3 = {8'hC2, 8'hC1, 8'hC0};
        validos3  = 3'b111;
        modo3     = 1'b0;
        selecao3  = 2'd0;
        pronta3   = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({valida4, canal4, saida4} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset4: got v=%b c=%0d d=%h expected all zero", valida4, canal4, saida4);
        end
        tests_run++;
        if ({valida3, canal3, saida3} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset3: got v=%b c=%0d d=%h expected all zero", valida3, canal3, saida3);
        end
        // Load a word and stall it, then reset on top of it.
        reset   = 1'b0;
        pronta4 = 1'b0;
        sb.push_back(item_t'{canal: 2'd0, dado: 8'h10});
        tick();
        esp = sb.pop_front();
        tests_run++;
        if ({valida4, canal4, saida4} !== {1'b1, esp.canal, esp.dado}) begin
            tests_failed++;
            $display("FAIL reset_preload: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                     valida4, canal4, saida4, esp.canal, esp.dado);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({valida4, canal4, saida4} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_midxfer: got v=%b c=%0d d=%h expected all zero",
                     valida4, canal4, saida4);
        end
    endtask

    task automatic test_direct();
        logic [7:0] dados [4];
        int         ordem [4];
        dados     = '{8'h11, 8'h22, 8'hA5, 8'h33};
        ordem     = '{2, 0, 3, 1};
        entradas4 = {dados[3], dados[2], dados[1], dados[0]};
        modo4     = 1'b0;
        validos4  = 4'b1111;
        pronta4   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            selecao4 = 2'(ordem[i]);
            @(negedge clock);
            tests_run++;
            if (prontos4 !== 4'(1 << ordem[i])) begin
                tests_failed++;
                $display("FAIL direct_prontos sel=%0d: got %b expected %b",
                         ordem[i], prontos4, 4'(1 << ordem[i]));
            end
            sb.push_back(item_t'{canal: 2'(ordem[i]), dado: dados[ordem[i]]});
            tick();
            esp = sb.pop_front();
            tests_run++;
            if ({valida4, canal4, saida4} !== {1'b1, esp.canal, esp.dado}) begin
                tests_failed++;
                $display("FAIL direct_out: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                         valida4, canal4, saida4, esp.canal, esp.dado);
            end
        end
        selecao4 = 2'd1;
        validos4 = 4'b1101;
        @(negedge clock);
        tests_run++;
        if (prontos4 !== 4'b0000) begin
            tests_failed++;
            $display("FAIL direct_nogrant_prontos: got %b expected 0000", prontos4);
        end
        tick();
        tests_run++;
        if ({valida4, canal4, saida4} !== {1'b0, 2'd1, 8'h22}) begin
            tests_failed++;
            $display("FAIL direct_nogrant_out: got v=%b c=%0d d=%h expected v=0 c=1 d=22",
                     valida4, canal4, saida4);
        end
    endtask

    task automatic test_backpressure();
        modo4     = 1'b0;
        selecao4  = 2'd1;
        validos4  = 4'b0010;
        entradas4 = {8'h03, 8'h02, 8'h5A, 8'h00};
        pronta4   = 1'b1;
        @(negedge clock);
        tests_run++;
        if (prontos4 !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_first_prontos: got %b expected 0010", prontos4);
        end
        sb.push_back(item_t'{canal: 2'd1, dado: 8'h5A});
        tick();
        esp = sb.pop_front();
        pronta4 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            entradas4[15:8] = 8'h60 + 8'(j);
            @(negedge clock);
            tests_run++;
            if (prontos4 !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_stall_prontos %0d: got %b expected 0000", j, prontos4);
            end
            tick();
            tests_run++;
            if ({valida4, canal4, saida4} !== {1'b1, esp.canal, esp.dado}) begin
                tests_failed++;
                $display("FAIL bp_stall_out %0d: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                         j, valida4, canal4, saida4, esp.canal, esp.dado);
            end
        end
        entradas4[15:8] = 8'h77;
        pronta4         = 1'b1;
        @(negedge clock);
        tests_run++;
        if (prontos4 !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_release_prontos: got %b expected 0010", prontos4);
        end
        sb.push_back(item_t'{canal: 2'd1, dado: 8'h77});
        tick();
        esp = sb.pop_front();
        tests_run++;
        if ({valida4, canal4, saida4} !== {1'b1, esp.canal, esp.dado}) begin
            tests_failed++;
            $display("FAIL bp_release_out: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                     valida4, canal4, saida4, esp.canal, esp.dado);
        end
    endtask

    task automatic test_round_robin();
        int         seq [8];
        logic [3:0] pad [8];
        seq = '{0, 1, 2, 3, 0, 1, 3, 1};
        pad = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1010, 4'b1010, 4'b1010};
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        modo4     = 1'b1;
        pronta4   = 1'b1;
        entradas4 = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int i = 0; i < 8; i++) begin
            validos4 = pad[i];
            @(negedge clock);
            tests_run++;
            if (prontos4 !== 4'(1 << seq[i])) begin
                tests_failed++;
                $display("FAIL rr_prontos step %0d: got %b expected %b",
                         i, prontos4, 4'(1 << seq[i]));
            end
            sb.push_back(item_t'{canal: 2'(seq[i]), dado: 8'h40 + 8'(seq[i])});
            tick();
            esp = sb.pop_front();
            tests_run++;
            if ({valida4, canal4, saida4} !== {1'b1, esp.canal, esp.dado}) begin
                tests_failed++;
                $display("FAIL rr_out step %0d: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                         i, valida4, canal4, saida4, esp.canal, esp.dado);
            end
        end
    endtask

    task automatic test_wrap3();
        int seq [4];
        seq   = '{0, 2, 0, 2};
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        modo3     = 1'b1;
        validos3  = 3'b101;
        pronta3   = 1'b1;
        entradas3 = {8'hC2, 8'hC1, 8'hC0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            tests_run++;
            if (prontos3 !== 3'(1 << seq[i])) begin
                tests_failed++;
                $display("FAIL wrap3_prontos step %0d: got %b expected %b",
                         i, prontos3, 3'(1 << seq[i]));
            end
            sb.push_back(item_t'{canal: 2'(seq[i]), dado: 8'hC0 + 8'(seq[i])});
            tick();
            esp = sb.pop_front();
            tests_run++;
            if ({valida3, canal3, saida3} !== {1'b1, esp.canal, esp.dado}) begin
                tests_failed++;
                $display("FAIL wrap3_out step %0d: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                         i, valida3, canal3, saida3, esp.canal, esp.dado);
            end
        end
    endtask

    task automatic test_out_of_range();
        modo3    = 1'b0;
        selecao3 = 2'd1;
        validos3 = 3'b111;
        pronta3  = 1'b1;
        @(negedge clock);
        tests_run++;
        if (prontos3 !== 3'b010) begin
            tests_failed++;
            $display("FAIL oor_load_prontos: got %b expected 010", prontos3);
        end
        sb.push_back(item_t'{canal: 2'd1, dado: 8'hC1});
        tick();
        esp      = sb.pop_front();
        selecao3 = 2'd3;
        pronta3  = 1'b0;
        @(negedge clock);
        tests_run++;
        if (prontos3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL oor_stall_prontos: got %b expected 000", prontos3);
        end
        tick();
        tests_run++;
        if ({valida3, canal3, saida3} !== {1'b1, esp.canal, esp.dado}) begin
            tests_failed++;
            $display("FAIL oor_held: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                     valida3, canal3, saida3, esp.canal, esp.dado);
        end
        pronta3 = 1'b1;
        @(negedge clock);
        tests_run++;
        if (prontos3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL oor_drain_prontos: got %b expected 000", prontos3);
        end
        tick();
        tests_run++;
        if ({valida3, canal3, saida3} !== {1'b0, esp.canal, esp.dado}) begin
            tests_failed++;
            $display("FAIL oor_drained: got v=%b c=%0d d=%h expected v=0 c=%0d d=%h",
                     valida3, canal3, saida3, esp.canal, esp.dado);
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_backpressure();
        test_round_robin();
        test_wrap3();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
